// File: rtl/wavegen_pkg.sv
// Shared codes for the waveform generator control front-end: waveform ids,
// sequencer states, the auto-noisy shift code and the applied-config record.
package wavegen_pkg;

    typedef enum logic [2:0] {
        WF_SIN    = 3'd0,
        WF_SQUARE = 3'd1,
        WF_TRI    = 3'd2,
        WF_ECG    = 3'd3,
        WF_SAW    = 3'd4
    } waveform_t;

    localparam logic [2:0] WF_LAST = 3'd4;

    typedef enum logic [1:0] {
        SEQ_MANUAL     = 2'd0,
        SEQ_AUTO_CLEAN = 2'd1,
        SEQ_AUTO_NOISY = 2'd2
    } seq_state_t;

    localparam logic [1:0] SHIFT_AUTO_NOISY = 2'd3;

    typedef struct packed {
        logic [2:0] wf;
        logic       noise;
        logic [1:0] shift;
        logic [7:0] duty;
        logic [3:0] idx;
    } cfg_t;

    function automatic logic [2:0] next_wf(input logic [2:0] wf);
        return (wf >= WF_LAST) ? 3'(WF_SIN) : wf + 3'd1;
    endfunction

endpackage

// File: rtl/wavegen_ctrl_if.sv
// Config bus between the control front-end (master) and waveform_generator (slave).
// cfg_update is a one-cycle valid pulse with no ready: the generator must take the
// new values on that cycle. cycle_wrap is the generator's phase-wrap strobe.
interface wavegen_ctrl_if;
    logic        cycle_wrap;
    logic [2:0]  waveform_select;
    logic        noise_enable;
    logic [1:0]  shift_sel;
    logic [7:0]  duty_cycle;
    logic [3:0]  freq_idx;
    logic [31:0] phase_inc;
    logic        cfg_update;

    modport master (
        input  cycle_wrap,
        output waveform_select, noise_enable, shift_sel, duty_cycle,
        output freq_idx, phase_inc, cfg_update
    );

    modport slave (
        output cycle_wrap,
        input  waveform_select, noise_enable, shift_sel, duty_cycle,
        input  freq_idx, phase_inc, cfg_update
    );
endinterface

// File: rtl/wavegen_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-high counter, and a single
// registered press pulse per press (re-armed only after the level reads 0).
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The counter parks at DEB_CYCLES while held, which blocks any repeat fire.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (!sync_q[1]) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEB_CYCLES)) begin
            cnt_d   = cnt_q + CW'(1);
            press_d = (cnt_q == CW'(DEB_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;
endmodule

// File: rtl/wavegen_ctrl.sv
// Control front-end for waveform_generator: debounced frequency buttons, auto-demo
// sequencer, and a shadow config that is applied glitch-free on cycle_wrap.
module wavegen_ctrl
    import wavegen_pkg::*;
#(
    parameter int          DEB_CYCLES   = 1_000_000,
    parameter int          DWELL_CYCLES = 50_000_000,
    parameter int          WRAP_TIMEOUT = 1_000_000,
    parameter int          MAX_IDX      = 15,
    parameter logic [31:0] BASE_INC     = 32'd4096,
    parameter logic [7:0]  DUTY_RST     = 8'd50
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          button_freq_inc,
    input  logic          button_freq_dec,
    input  logic          auto_mode,
    input  logic [2:0]    waveform_select_in,
    input  logic          noise_enable_in,
    input  logic [1:0]    shift_sel_in,
    input  logic [7:0]    duty_cycle_in,
    output logic [1:0]    seq_state,
    wavegen_ctrl_if.master gen
);
    localparam int DWW = $clog2(DWELL_CYCLES);
    localparam int TW  = $clog2(WRAP_TIMEOUT);
    localparam cfg_t CFG_RST = '{wf: 3'd0, noise: 1'b0, shift: 2'd0, duty: DUTY_RST, idx: 4'd0};

    logic inc_evt, dec_evt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(reset), .btn_raw(button_freq_inc), .press(inc_evt)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk(clk), .rst(reset), .btn_raw(button_freq_dec), .press(dec_evt)
    );

    logic [3:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (inc_evt && !dec_evt && idx_q != 4'(MAX_IDX)) begin
            idx_d = idx_q + 4'd1;
        end else if (dec_evt && !inc_evt && idx_q != 4'd0) begin
            idx_d = idx_q - 4'd1;
        end
    end

    seq_state_t     state_q;
    logic [2:0]     seq_wf_q;
    logic [DWW-1:0] dwell_q;

    // Dwell timing is independent of the apply path, so a silent generator never stalls it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= SEQ_MANUAL;
            seq_wf_q <= 3'(WF_SIN);
            dwell_q  <= '0;
        end else if (!auto_mode) begin
            state_q  <= SEQ_MANUAL;
            seq_wf_q <= 3'(WF_SIN);
            dwell_q  <= '0;
        end else begin
            case (state_q)
                SEQ_MANUAL: begin
                    state_q  <= SEQ_AUTO_CLEAN;
                    seq_wf_q <= 3'(WF_SIN);
                    dwell_q  <= '0;
                end
                SEQ_AUTO_CLEAN: begin
                    if (dwell_q == DWW'(DWELL_CYCLES - 1)) begin
                        state_q <= SEQ_AUTO_NOISY;
                        dwell_q <= '0;
                    end else begin
                        dwell_q <= dwell_q + DWW'(1);
                    end
                end
                SEQ_AUTO_NOISY: begin
                    if (dwell_q == DWW'(DWELL_CYCLES - 1)) begin
                        state_q  <= SEQ_AUTO_CLEAN;
                        seq_wf_q <= next_wf(seq_wf_q);
                        dwell_q  <= '0;
                    end else begin
                        dwell_q <= dwell_q + DWW'(1);
                    end
                end
                default: begin
                    state_q  <= SEQ_MANUAL;
                    seq_wf_q <= 3'(WF_SIN);
                    dwell_q  <= '0;
                end
            endcase
        end
    end

    cfg_t          shadow, applied_q, applied_d;
    logic [TW-1:0] to_q, to_d;
    logic [31:0]   phase_inc_q, phase_inc_d;
    logic          cfg_update_q, cfg_update_d;
    logic          pending, apply;

    always_comb begin
        shadow       = '0;
        shadow.duty  = duty_cycle_in;
        shadow.idx   = idx_q;
        if (state_q == SEQ_MANUAL) begin
            shadow.wf    = waveform_select_in;
            shadow.noise = noise_enable_in;
            shadow.shift = shift_sel_in;
        end else begin
            shadow.wf    = seq_wf_q;
            shadow.noise = (state_q == SEQ_AUTO_NOISY);
            shadow.shift = (state_q == SEQ_AUTO_NOISY) ? SHIFT_AUTO_NOISY : 2'd0;
        end

        pending      = (shadow != applied_q);
        apply        = pending && (gen.cycle_wrap || to_q == TW'(WRAP_TIMEOUT - 1));
        to_d         = (!pending || apply) ? '0 : to_q + TW'(1);
        applied_d    = apply ? shadow : applied_q;
        phase_inc_d  = apply ? (BASE_INC << shadow.idx) : phase_inc_q;
        cfg_update_d = apply;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= 4'd0;
            applied_q    <= CFG_RST;
            to_q         <= '0;
            phase_inc_q  <= BASE_INC;
            cfg_update_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            applied_q    <= applied_d;
            to_q         <= to_d;
            phase_inc_q  <= phase_inc_d;
            cfg_update_q <= cfg_update_d;
        end
    end

    assign gen.waveform_select = applied_q.wf;
    assign gen.noise_enable    = applied_q.noise;
    assign gen.shift_sel       = applied_q.shift;
    assign gen.duty_cycle      = applied_q.duty;
    assign gen.freq_idx        = applied_q.idx;
    assign gen.phase_inc       = phase_inc_q;
    assign gen.cfg_update      = cfg_update_q;
    assign seq_state           = state_q;
endmodule

// File: tb/tb_wavegen_ctrl.sv
// Self-checking bench for wavegen_ctrl: button presses against a clamp model,
// wrap-aligned and forced applies, auto-demo phase schedule, async reset.
module tb_wavegen_ctrl;
    import wavegen_pkg::*;

    localparam int DEB   = 4;
    localparam int DWELL = 16;
    localparam int WTO   = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       button_freq_inc, button_freq_dec, auto_mode;
    logic [2:0] waveform_select_in;
    logic       noise_enable_in;
    logic [1:0] shift_sel_in;
    logic [7:0] duty_cycle_in;
    logic [1:0] seq_state;

    wavegen_ctrl_if gen();

    wavegen_ctrl #(
        .DEB_CYCLES(DEB), .DWELL_CYCLES(DWELL), .WRAP_TIMEOUT(WTO),
        .MAX_IDX(15), .BASE_INC(32'd1), .DUTY_RST(8'd50)
    ) dut (
        .clk(clk), .reset(reset),
        .button_freq_inc(button_freq_inc), .button_freq_dec(button_freq_dec),
        .auto_mode(auto_mode), .waveform_select_in(waveform_select_in),
        .noise_enable_in(noise_enable_in), .shift_sel_in(shift_sel_in),
        .duty_cycle_in(duty_cycle_in), .seq_state(seq_state), .gen(gen)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_idx = 0;
    int wrap_period = 0;
    int wrap_cnt = 0;
    int cfg_cnt = 0;
    int nowrap_cnt = 0;
    bit wrap_last = 1'b0;
    logic [5:0] exp_q[$];

    // Generator stand-in: wrap strobe every wrap_period cycles, 0 disables it.
    initial begin
        gen.cycle_wrap = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (wrap_period > 0) begin
                wrap_cnt++;
                if (wrap_cnt >= wrap_period) begin
                    gen.cycle_wrap = 1'b1;
                    wrap_cnt = 0;
                end else begin
                    gen.cycle_wrap = 1'b0;
                end
            end else begin
                gen.cycle_wrap = 1'b0;
                wrap_cnt = 0;
            end
        end
    end

    // Counts cfg_update pulses, and those not preceded by a sampled wrap.
    initial begin
        forever begin
            @(negedge clk);
            if (gen.cfg_update) cfg_cnt++;
            if (gen.cfg_update && !wrap_last) nowrap_cnt++;
            wrap_last = gen.cycle_wrap;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input bit inc, input bit dec, input int hold, input int gap);
        button_freq_inc = inc;
        button_freq_dec = dec;
        step(hold);
        button_freq_inc = 1'b0;
        button_freq_dec = 1'b0;
        step(gap);
    endtask

    function automatic int clamp_idx(input int v);
        if (v < 0) return 0;
        if (v > 15) return 15;
        return v;
    endfunction

    task automatic test_reset;
        int c0;
        reset = 1'b1;
        step(3);
        checks++;
        if (gen.waveform_select !== 3'd0 || gen.noise_enable !== 1'b0 || gen.shift_sel !== 2'd0 ||
            gen.duty_cycle !== 8'd50 || gen.freq_idx !== 4'd0 || gen.phase_inc !== 32'd1 ||
            gen.cfg_update !== 1'b0 || seq_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: got wf=%0d n=%0d sh=%0d duty=%0d idx=%0d inc=%0d upd=%0d st=%0d, expected 0/0/0/50/0/1/0/0",
                     gen.waveform_select, gen.noise_enable, gen.shift_sel, gen.duty_cycle,
                     gen.freq_idx, gen.phase_inc, gen.cfg_update, seq_state);
        end
        reset = 1'b0;
        wrap_period = 20;
        c0 = cfg_cnt;
        step(100);
        checks++;
        if (cfg_cnt !== c0) begin
            errors++;
            $display("FAIL idle_no_update: got %0d pulses, expected 0", cfg_cnt - c0);
        end
        checks++;
        if (gen.freq_idx !== 4'd0 || gen.phase_inc !== 32'd1 || gen.duty_cycle !== 8'd50 ||
            gen.waveform_select !== 3'd0) begin
            errors++;
            $display("FAIL idle_values: got idx=%0d inc=%0d duty=%0d wf=%0d, expected 0/1/50/0",
                     gen.freq_idx, gen.phase_inc, gen.duty_cycle, gen.waveform_select);
        end
    endtask

    task automatic test_inc;
        int c0, v0;
        c0 = cfg_cnt;
        v0 = nowrap_cnt;
        repeat (3) press(1'b1, 1'b0, 10, 10);
        step(25);
        model_idx = clamp_idx(model_idx + 3);
        checks++;
        if (gen.freq_idx !== 4'(model_idx) || gen.phase_inc !== (32'd1 << model_idx)) begin
            errors++;
            $display("FAIL inc_three: got idx=%0d inc=%0d, expected idx=%0d inc=%0d",
                     gen.freq_idx, gen.phase_inc, model_idx, 32'd1 << model_idx);
        end
        checks++;
        if (cfg_cnt - c0 !== 3) begin
            errors++;
            $display("FAIL inc_pulses: got %0d, expected 3", cfg_cnt - c0);
        end
        checks++;
        if (nowrap_cnt !== v0) begin
            errors++;
            $display("FAIL inc_wrap_aligned: got %0d unaligned pulses, expected 0", nowrap_cnt - v0);
        end
    endtask

    task automatic test_dec;
        press(1'b0, 1'b1, 8, 6);
        model_idx = clamp_idx(model_idx - 1);
        step(30);
        checks++;
        if (gen.freq_idx !== 4'(model_idx) || gen.phase_inc !== (32'd1 << model_idx)) begin
            errors++;
            $display("FAIL dec_one: got idx=%0d inc=%0d, expected idx=%0d", gen.freq_idx, gen.phase_inc, model_idx);
        end
        repeat (5) begin
            press(1'b0, 1'b1, 8, 6);
            model_idx = clamp_idx(model_idx - 1);
        end
        step(30);
        checks++;
        if (gen.freq_idx !== 4'd0 || gen.phase_inc !== 32'd1 || model_idx != 0) begin
            errors++;
            $display("FAIL dec_saturate: got idx=%0d inc=%0d, expected idx=0 inc=1", gen.freq_idx, gen.phase_inc);
        end
    endtask

    task automatic test_simultaneous;
        int c0;
        press(1'b1, 1'b0, 8, 6);
        model_idx = clamp_idx(model_idx + 1);
        step(30);
        c0 = cfg_cnt;
        press(1'b1, 1'b1, 8, 6);
        step(30);
        checks++;
        if (gen.freq_idx !== 4'(model_idx)) begin
            errors++;
            $display("FAIL both_cancel_idx: got %0d, expected %0d", gen.freq_idx, model_idx);
        end
        checks++;
        if (cfg_cnt !== c0) begin
            errors++;
            $display("FAIL both_cancel_pulse: got %0d pulses, expected 0", cfg_cnt - c0);
        end
    endtask

    task automatic test_random_buttons;
        for (int i = 0; i < 16; i++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                press(1'b1, 1'b0, $urandom_range(DEB + 2, 12), $urandom_range(3, 8));
                model_idx = clamp_idx(model_idx + 1);
            end else if (op == 1) begin
                press(1'b0, 1'b1, $urandom_range(DEB + 2, 12), $urandom_range(3, 8));
                model_idx = clamp_idx(model_idx - 1);
            end else begin
                // Too short to qualify: must never register.
                press($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(1, 2), $urandom_range(3, 8));
            end
            if (i == 7 || i == 15) begin
                step(30);
                checks++;
                if (gen.freq_idx !== 4'(model_idx) || gen.phase_inc !== (32'd1 << model_idx)) begin
                    errors++;
                    $display("FAIL random_buttons[%0d]: got idx=%0d inc=%0d, expected idx=%0d",
                             i, gen.freq_idx, gen.phase_inc, model_idx);
                end
            end
        end
    endtask

    task automatic test_saturate_top;
        repeat (17) begin
            press(1'b1, 1'b0, DEB + 2, 3);
            model_idx = clamp_idx(model_idx + 1);
        end
        step(30);
        checks++;
        if (gen.freq_idx !== 4'd15 || gen.phase_inc !== 32'd32768 || model_idx != 15) begin
            errors++;
            $display("FAIL inc_saturate: got idx=%0d inc=%0d, expected idx=15 inc=32768", gen.freq_idx, gen.phase_inc);
        end
    endtask

    task automatic test_forced_apply;
        int c0, lat;
        wrap_period = 0;
        step(30);
        c0 = cfg_cnt;
        lat = 0;
        waveform_select_in = 3'd2;
        for (int i = 1; i <= WTO + 20; i++) begin
            step(1);
            if (gen.cfg_update) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != WTO) begin
            errors++;
            $display("FAIL forced_latency: got %0d cycles (0 = none), expected %0d", lat, WTO);
        end
        checks++;
        if (gen.waveform_select !== 3'd2) begin
            errors++;
            $display("FAIL forced_value: got wf=%0d, expected 2", gen.waveform_select);
        end
        step(20);
        checks++;
        if (cfg_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL forced_pulses: got %0d, expected 1", cfg_cnt - c0);
        end
    endtask

    task automatic test_timeout_no_restart;
        int lat;
        lat = 0;
        waveform_select_in = 3'd1;
        step(30);
        waveform_select_in = 3'd3;
        for (int i = 31; i <= WTO + 20; i++) begin
            step(1);
            if (gen.cfg_update) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != WTO || gen.waveform_select !== 3'd3) begin
            errors++;
            $display("FAIL timeout_no_restart: got latency=%0d wf=%0d, expected latency=%0d wf=3",
                     lat, gen.waveform_select, WTO);
        end
    endtask

    task automatic test_auto;
        int phase;
        logic [5:0] exp_cfg, got_cfg;
        waveform_select_in = 3'd0;
        wrap_period = 4;
        for (int p = 0; p < 12; p++) begin
            exp_q.push_back({3'((p / 2) % 5), 1'(p % 2), (p % 2 == 1) ? 2'd3 : 2'd0});
        end
        auto_mode = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step(1);
            phase = k / DWELL;
            checks++;
            if (seq_state !== ((phase % 2 == 1) ? 2'd2 : 2'd1)) begin
                errors++;
                $display("FAIL auto_state[k=%0d]: got %0d, expected %0d", k, seq_state, (phase % 2 == 1) ? 2 : 1);
            end
            if (k % DWELL == 12 && exp_q.size() > 0) begin
                exp_cfg = exp_q.pop_front();
                got_cfg = {gen.waveform_select, gen.noise_enable, gen.shift_sel};
                checks++;
                if (got_cfg !== exp_cfg || gen.duty_cycle !== 8'd50 || gen.freq_idx !== 4'(model_idx)) begin
                    errors++;
                    $display("FAIL auto_phase[%0d]: got wf/n/sh=%0d/%0d/%0d duty=%0d idx=%0d, expected %0d/%0d/%0d duty=50 idx=%0d",
                             phase, gen.waveform_select, gen.noise_enable, gen.shift_sel, gen.duty_cycle,
                             gen.freq_idx, exp_cfg[5:3], exp_cfg[2], exp_cfg[1:0], model_idx);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL auto_phase_count: got %0d unchecked phases, expected 0", exp_q.size());
        end
        auto_mode = 1'b0;
        step(1);
        checks++;
        if (seq_state !== 2'd0) begin
            errors++;
            $display("FAIL auto_exit: got %0d, expected 0", seq_state);
        end
    endtask

    task automatic test_reset_async;
        int c0;
        wrap_period = 20;
        auto_mode = 1'b1;
        step(1 + DWELL + 5);
        checks++;
        if (seq_state !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_state: got %0d, expected 2", seq_state);
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        auto_mode = 1'b0;
        #1;
        checks++;
        if (gen.waveform_select !== 3'd0 || gen.noise_enable !== 1'b0 || gen.shift_sel !== 2'd0 ||
            gen.duty_cycle !== 8'd50 || gen.freq_idx !== 4'd0 || gen.phase_inc !== 32'd1 ||
            gen.cfg_update !== 1'b0 || seq_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_noisy: got wf=%0d n=%0d sh=%0d duty=%0d idx=%0d inc=%0d st=%0d, expected 0/0/0/50/0/1/0",
                     gen.waveform_select, gen.noise_enable, gen.shift_sel, gen.duty_cycle,
                     gen.freq_idx, gen.phase_inc, seq_state);
        end
        model_idx = 0;
        step(2);
        reset = 1'b0;
        step(2);
        button_freq_inc = 1'b1;
        step(3);
        @(negedge clk);
        #1;
        reset = 1'b1;
        button_freq_inc = 1'b0;
        #1;
        checks++;
        if (gen.freq_idx !== 4'd0 || gen.cfg_update !== 1'b0 || seq_state !== 2'd0) begin
            errors++;
            $display("FAIL async_reset_debounce: got idx=%0d upd=%0d st=%0d, expected 0/0/0",
                     gen.freq_idx, gen.cfg_update, seq_state);
        end
        step(2);
        reset = 1'b0;
        c0 = cfg_cnt;
        step(40);
        checks++;
        if (gen.freq_idx !== 4'd0 || gen.phase_inc !== 32'd1 || cfg_cnt !== c0) begin
            errors++;
            $display("FAIL partial_press_dropped: got idx=%0d inc=%0d pulses=%0d, expected 0/1/0",
                     gen.freq_idx, gen.phase_inc, cfg_cnt - c0);
        end
    endtask

    initial begin
        reset = 1'b1;
        button_freq_inc = 1'b0;
        button_freq_dec = 1'b0;
        auto_mode = 1'b0;
        waveform_select_in = 3'd0;
        noise_enable_in = 1'b0;
        shift_sel_in = 2'd0;
        duty_cycle_in = 8'd50;
        test_reset();
        test_inc();
        test_dec();
        test_simultaneous();
        test_random_buttons();
        test_saturate_top();
        test_forced_apply();
        test_timeout_no_restart();
        test_auto();
        test_reset_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no completion by 200000 ns, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/wavegen_ctrl.md
Name: wavegen_ctrl

Overview:
- Control front-end for waveform_generator.
- Debounces the frequency inc/dec buttons and maintains a saturating frequency index and phase increment.
- Runs an auto-demo sequencer that steps through all five waveforms, clean then noisy.
- Applies every configuration change glitch-free, on the generator's phase-wrap strobe.

Parameters:
- DEB_CYCLES, 1_000_000, stable-high cycles required to accept a button press.
- DWELL_CYCLES, 50_000_000, cycles spent in each auto-demo phase.
- WRAP_TIMEOUT, 1_000_000, max cycles a pending change waits for cycle_wrap before a forced apply.
- MAX_IDX, 15, top frequency index (inclusive).
- BASE_INC, 32'd4096, phase increment at index 0.
- DUTY_RST, 8'd50, reset duty_cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- button_freq_inc  in  1  raw button, async to clk
- button_freq_dec  in  1  raw button, async to clk
- auto_mode  in  1  1 = auto-demo sequencer, 0 = manual
- waveform_select_in  in  3  manual waveform (0 sin, 1 square, 2 tri, 3 ECG, 4 saw)
- noise_enable_in  in  1  manual noise enable
- shift_sel_in  in  2  manual noise shift
- duty_cycle_in  in  8  manual duty
- cycle_wrap  in  1  one-cycle strobe from the generator at phase-accumulator wrap
- waveform_select  out  3  applied waveform
- noise_enable  out  1  applied noise enable
- shift_sel  out  2  applied shift
- duty_cycle  out  8  applied duty
- freq_idx  out  4  applied frequency index
- phase_inc  out  32  BASE_INC << freq_idx, registered
- cfg_update  out  1  one-cycle pulse on the edge the applied outputs change
- seq_state  out  2  0 MANUAL, 1 AUTO_CLEAN, 2 AUTO_NOISY

Behaviour:
- Reset (async, any time, including mid-debounce or mid-dwell):
  - waveform_select=0, noise_enable=0, shift_sel=0, duty_cycle=DUTY_RST, freq_idx=0, phase_inc=BASE_INC, cfg_update=0, seq_state=MANUAL.
  - Debounce counters, dwell timer, pending flag and timeout counter clear.
- Button synchronisation and debounce:
  - Each button passes a 2-FF synchroniser.
  - A per-button counter increments while the synced level is 1 and clears on 0.
  - Reaching DEB_CYCLES produces exactly one press event per press. No repeat while held; the button must read 0 before it can fire again.
- Frequency index:
  - An inc event raises shadow idx, saturating at MAX_IDX.
  - A dec event lowers shadow idx, saturating at 0.
  - Inc and dec events in the same cycle cancel (no change).
  - Buttons remain active in auto mode.
- Shadow configuration:
  - MANUAL: waveform, noise, shift and duty are copied from the *_in ports every cycle.
  - AUTO: these come from the sequencer. AUTO_CLEAN gives noise=0, shift=0. AUTO_NOISY gives noise=1, shift=3. duty is always duty_cycle_in.
- Apply mechanism:
  - pending = (shadow != applied), evaluated every cycle.
  - If pending and cycle_wrap=1, the next edge copies shadow to the outputs and pulses cfg_update.
  - If pending persists for WRAP_TIMEOUT cycles without a wrap, a forced apply happens the same way.
  - The timeout counter clears whenever pending=0 or an apply occurs.
  - A shadow change while already pending does not restart the timeout.
  - cycle_wrap with pending=0 does nothing (no pulse).
  - phase_inc updates on the same edge as freq_idx.
- Sequencer FSM:
  - MANUAL with auto_mode=1: go to AUTO_CLEAN, seq waveform=0, dwell timer=0.
  - AUTO_CLEAN: timer reaching DWELL_CYCLES-1 goes to AUTO_NOISY, timer=0.
  - AUTO_NOISY: timer reaching DWELL_CYCLES-1 goes to AUTO_CLEAN, seq waveform increments, wrapping 4 to 0, timer=0.
  - auto_mode=0 in any AUTO state returns to MANUAL on the next edge. Sequencer waveform and timer reset.
  - The dwell timer runs regardless of apply status. Sequencing is never stalled by a missing cycle_wrap.
- Outputs are all registered. No combinational path from inputs to outputs.

Decomposition:
- Package wavegen_pkg holds:
  - waveform codes (WF_SIN..WF_SAW, WF_LAST=4);
  - seq_state encodings;
  - shift code SHIFT_AUTO_NOISY=2'd3.
- One natural sub-module, btn_debounce (synchroniser + counter + single-shot edge, parameter DEB_CYCLES), instantiated twice.

Test Plan (DEB_CYCLES=4, DWELL_CYCLES=16, WRAP_TIMEOUT=64, BASE_INC=1, cycle_wrap pulsed every 20 cycles unless stated):
- Reset then idle for 100 cycles -> outputs 0/0/0/50, freq_idx=0, phase_inc=1, cfg_update never asserts.
- Hold inc for 10 cycles, release, repeat 3 times -> one event per press. freq_idx=3, phase_inc=8, each change landing with cfg_update exactly in the cycle after a cycle_wrap.
- Press dec 5 times from idx=2 -> freq_idx saturates at 0. Press inc and dec simultaneously -> no change, no cfg_update.
- cycle_wrap tied low, set waveform_select_in=2 -> forced apply after 64 cycles, one cfg_update pulse, waveform_select=2.
- auto_mode=1 for 200 cycles with wrap every 4 cycles -> seq_state alternates 1/2 every 16 cycles. Outputs step sin-clean, sin-noisy(shift=3), square-clean, ... and wrap from 4 to 0.
- Assert reset in mid-AUTO_NOISY and in mid-debounce -> all outputs return to reset values immediately (async). The partial press does not generate an event after release of reset.
